// File: rtl/des_round_ctrl.sv
// des_round_ctrl: iterative DES round sequencer (control only, no data registers).
// Accepts one block over a valid/ready handshake. It then steps the shared Feistel round
// datapath through ROUNDS rounds, drives the key-schedule rotate commands and the final-swap
// strobe, and holds the result valid until the consumer takes it.
//
// Ports
//   clk, rst         rising-edge clock; asynchronous active-high reset
//   in_valid/in_mode request present / 0=encrypt 1=decrypt (mode sampled on accept)
//   in_ready         high only in IDLE (combinational)
//   abort            synchronous kill of the in-flight block
//   ld_block         1-cycle load strobe for IP(block) and PC1(key)
//   round_en         datapath round capture strobe (combinational)
//   round_cnt        current round 0..ROUNDS-1
//   key_shift        key rotate amount 0/1/2, meaningful while round_en=1 (combinational)
//   key_dir          0=rotate left (enc), 1=rotate right (dec)
//   swap_final       last-round strobe: skip L/R swap, apply FP (combinational)
//   mode_q           registered mode of the in-flight block
//   busy             state != IDLE
//   out_valid/out_ready  result handshake
module des_round_ctrl #(
  parameter int unsigned ROUNDS       = 16,
  parameter int unsigned ROUND_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_mode,
  output logic       in_ready,
  input  logic       abort,
  output logic       ld_block,
  output logic       round_en,
  output logic [3:0] round_cnt,
  output logic [1:0] key_shift,
  output logic       key_dir,
  output logic       swap_final,
  output logic       mode_q,
  output logic       busy,
  output logic       out_valid,
  input  logic       out_ready
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned SUB_W = 3;
  localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS - 1);
  localparam logic [SUB_W-1:0] LAST_SUB   = SUB_W'(ROUND_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] round_cnt_q, round_cnt_d;
  logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
  logic             mode_d;
  logic             ld_block_q, busy_q, out_valid_q;

  // State, counters and registered outputs; flag outputs are decoded from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      round_cnt_q <= '0;
      sub_cnt_q   <= '0;
      mode_q      <= 1'b0;
      ld_block_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_cnt_q <= round_cnt_d;
      sub_cnt_q   <= sub_cnt_d;
      mode_q      <= mode_d;
      ld_block_q  <= (state_d == S_LOAD);
      busy_q      <= (state_d != S_IDLE);
      out_valid_q <= (state_d == S_DONE);
    end
  end

  // Next-state logic and the round strobe
  always_comb begin
    state_d     = state_q;
    round_cnt_d = round_cnt_q;
    sub_cnt_d   = sub_cnt_q;
    mode_d      = mode_q;
    in_ready    = (state_q == S_IDLE);
    round_en    = 1'b0;

    if (abort && (state_q != S_IDLE)) begin
      // Kill wins over everything: no round strobe this cycle, counters cleared
      state_d     = S_IDLE;
      round_cnt_d = '0;
      sub_cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // abort also blocks an accept in IDLE
          if (in_valid && !abort) begin
            state_d = S_LOAD;
            mode_d  = in_mode;
          end
        end
        S_LOAD: begin
          state_d = S_ROUND;
        end
        S_ROUND: begin
          if (sub_cnt_q == LAST_SUB) begin
            round_en  = 1'b1;
            sub_cnt_d = '0;
            if (round_cnt_q == LAST_ROUND) begin
              state_d     = S_DONE;
              round_cnt_d = '0;
            end else begin
              round_cnt_d = round_cnt_q + CNT_W'(1);
            end
          end else begin
            sub_cnt_d = sub_cnt_q + SUB_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Key-schedule rotate amount; decrypt starts from the unrotated key, so round 0 shifts 0
  always_comb begin
    key_shift = 2'd0;
    if (state_q == S_ROUND) begin
      case (round_cnt_q)
        4'd0:              key_shift = mode_q ? 2'd0 : 2'd1;
        4'd1, 4'd8, 4'd15: key_shift = 2'd1;
        default:           key_shift = 2'd2;
      endcase
    end
  end

  assign swap_final = round_en & (round_cnt_q == LAST_ROUND);
  assign round_cnt  = round_cnt_q;
  assign key_dir    = mode_q;
  assign ld_block   = ld_block_q;
  assign busy       = busy_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Testbench for des_round_ctrl: scoreboard of accepted blocks plus a key-register model that
// rotates a 28-bit C half by the DUT's key_shift/key_dir commands.
module tb_des_round_ctrl;

  localparam int ROUNDS = 16;
  localparam int LAT1   = 2 + ROUNDS * 1;
  localparam int LAT3   = 2 + ROUNDS * 3;
  localparam int B2B    = 3 + ROUNDS * 1;
  localparam logic [27:0] C0 = 28'hF0CCAAF;  // C half of PC1(133457799BBCDFF1)

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid, in_mode, abort, out_ready;
  logic       in_ready, ld_block, round_en, key_dir, swap_final, mode_q, busy, out_valid;
  logic [3:0] round_cnt;
  logic [1:0] key_shift;

  logic       in_valid3, in_mode3, abort3, out_ready3;
  logic       in_ready3, ld_block3, round_en3, key_dir3, swap_final3, mode_q3, busy3, out_valid3;
  logic [3:0] round_cnt3;
  logic [1:0] key_shift3;

  des_round_ctrl #(.ROUNDS(16), .ROUND_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_mode(in_mode), .in_ready(in_ready),
    .abort(abort), .ld_block(ld_block), .round_en(round_en), .round_cnt(round_cnt),
    .key_shift(key_shift), .key_dir(key_dir), .swap_final(swap_final), .mode_q(mode_q),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready)
  );

  des_round_ctrl #(.ROUNDS(16), .ROUND_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_mode(in_mode3), .in_ready(in_ready3),
    .abort(abort3), .ld_block(ld_block3), .round_en(round_en3), .round_cnt(round_cnt3),
    .key_shift(key_shift3), .key_dir(key_dir3), .swap_final(swap_final3), .mode_q(mode_q3),
    .busy(busy3), .out_valid(out_valid3), .out_ready(out_ready3)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Encrypt rotate schedule straight from the DES key schedule
  function automatic logic [1:0] exp_shift(input logic m, input int r);
    logic [1:0] enc [16];
    enc = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
            2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    if (m && r == 0) return 2'd0;
    return enc[r];
  endfunction

  function automatic logic [27:0] rot28(input logic [27:0] c, input logic [1:0] n, input logic dir);
    logic [27:0] r;
    r = c;
    for (int i = 0; i < int'(n); i++)
      r = dir ? {r[0], r[27:1]} : {r[26:0], r[27]};
    return r;
  endfunction

  typedef struct {
    logic mode;
    int   acc_cyc;
  } exp_t;

  exp_t        sb[$];
  int          rnd_idx  = 0;
  logic        ov_prev  = 1'b0;
  logic [27:0] kreg     = '0;
  logic [27:0] enc_k [16];
  logic        have_enc = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor for the ROUND_CYCLES=1 instance
  always @(negedge clk) begin : mon
    if (rst) begin
      sb.delete();
      rnd_idx = 0;
    end else begin
      if (ld_block) begin
        if (sb.size() == 0) check_eq("ld_block_orphan", 32'(ld_block), 32'd0);
        else begin
          check_eq("ld_block_lat", 32'(cyc - sb[0].acc_cyc), 32'd1);
          kreg = C0;
        end
      end
      if (round_en) begin
        if (sb.size() == 0) check_eq("round_en_orphan", 32'(round_en), 32'd0);
        else begin
          check_eq("round_cnt", 32'(round_cnt), 32'(rnd_idx));
          check_eq("key_shift", 32'(key_shift), 32'(exp_shift(sb[0].mode, rnd_idx)));
          check_eq("key_dir", 32'(key_dir), 32'(sb[0].mode));
          check_eq("swap_final", 32'(swap_final), 32'(rnd_idx == ROUNDS - 1));
          kreg = rot28(kreg, key_shift, key_dir);
          if (!sb[0].mode) enc_k[rnd_idx] = kreg;
          else if (have_enc) check_eq("dec_subkey", 32'(kreg), 32'(enc_k[ROUNDS-1-rnd_idx]));
          rnd_idx++;
        end
      end
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) check_eq("out_valid_orphan", 32'(out_valid), 32'd0);
        else begin
          check_eq("latency", 32'(cyc - sb[0].acc_cyc), 32'(LAT1));
          check_eq("out_mode", 32'(mode_q), 32'(sb[0].mode));
          check_eq("round_count", 32'(rnd_idx), 32'(ROUNDS));
          if (!sb[0].mode) begin
            check_eq("enc_rot28", 32'(kreg), 32'(C0));
            have_enc = 1'b1;
          end
        end
      end
      if (abort && busy) begin
        if (sb.size() != 0) void'(sb.pop_front());
        rnd_idx = 0;
      end else if (out_valid && out_ready) begin
        if (sb.size() != 0) void'(sb.pop_front());
        rnd_idx = 0;
      end
      if (in_valid && in_ready && !abort) sb.push_back('{in_mode, cyc});
    end
    ov_prev = out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present a request and hold it until accepted (bounded)
  task automatic send(input logic m);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_mode  = m;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready && !abort;
    end
    if (!ok) check_eq("send_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
    in_mode  = 1'($urandom);
  endtask

  task automatic wait_out();
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = out_valid;
    end
    if (!ok) check_eq("out_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_round(input int r);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = round_en && (int'(round_cnt) == r);
    end
    if (!ok) check_eq("round_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_ld_block"}, 32'(ld_block), 32'd0);
    check_eq({tag, "_round_en"}, 32'(round_en), 32'd0);
    check_eq({tag, "_round_cnt"}, 32'(round_cnt), 32'd0);
    check_eq({tag, "_key_shift"}, 32'(key_shift), 32'd0);
    check_eq({tag, "_swap_final"}, 32'(swap_final), 32'd0);
  endtask

  initial begin : main
    int prev, a3, last_re, n_re;
    bit ok;
    rst = 1'b1;
    in_valid = 1'b0; in_mode = 1'b0; abort = 1'b0; out_ready = 1'b1;
    in_valid3 = 1'b0; in_mode3 = 1'b0; abort3 = 1'b0; out_ready3 = 1'b1;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check_eq("reset_mode_q", 32'(mode_q), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Encrypt then decrypt at defaults
    send(1'b0);
    wait_out();
    tick();
    send(1'b1);
    wait_out();
    tick();

    // Backpressure in DONE: result held, new request ignored
    out_ready = 1'b0;
    send(1'b0);
    wait_out();
    tick();
    in_valid = 1'b1;
    in_mode  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_out_valid", 32'(out_valid), 32'd1);
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      check_eq("bp_busy", 32'(busy), 32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    check_eq("bp_release_in_ready", 32'(in_ready), 32'd1);
    check_eq("bp_release_out_valid", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("bp_next_ld_block", 32'(ld_block), 32'd1);
    wait_out();
    tick();

    // Abort in IDLE together with a request: nothing happens
    in_valid = 1'b1;
    abort    = 1'b1;
    tick();
    in_valid = 1'b0;
    abort    = 1'b0;
    @(negedge clk);
    check_eq("idle_abort_ld_block", 32'(ld_block), 32'd0);
    check_eq("idle_abort_busy", 32'(busy), 32'd0);
    tick();

    // Abort at round 7
    send(1'b0);
    wait_round(6);
    tick();
    abort = 1'b1;
    #1;
    check_eq("abort_round_cnt", 32'(round_cnt), 32'd7);
    check_eq("abort_no_round_en", 32'(round_en), 32'd0);
    check_eq("abort_no_swap", 32'(swap_final), 32'd0);
    tick();
    abort = 1'b0;
    check_idle_outputs("post_abort");
    repeat (3) begin
      @(negedge clk);
      check_eq("abort_quiet", 32'(round_en), 32'd0);
    end
    tick();

    // Asynchronous reset at round 3, then a normal block
    send(1'b1);
    wait_round(2);
    tick();
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_rst");
    check_eq("mid_rst_mode_q", 32'(mode_q), 32'd0);
    @(negedge clk);
    tick();
    rst = 1'b0;
    tick();
    send(1'b0);
    wait_out();
    tick();

    // Back-to-back with in_valid held and out_ready high; mode alternates
    in_valid = 1'b1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      in_mode = k[0];
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(negedge clk);
        ok = in_ready;
      end
      if (!ok) check_eq("b2b_timeout", 32'd0, 32'd1);
      if (k > 0) check_eq("b2b_period", 32'(cyc - prev), 32'(B2B));
      prev = cyc;
      tick();
    end
    in_valid = 1'b0;
    wait_out();
    tick();

    // ROUND_CYCLES=3 instance: a round strobe every third cycle
    in_valid3 = 1'b1;
    in_mode3  = 1'b0;
    @(negedge clk);
    check_eq("rc3_in_ready", 32'(in_ready3), 32'd1);
    a3 = cyc;
    tick();
    in_valid3 = 1'b0;
    n_re = 0;
    last_re = 0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (round_en3) begin
        if (n_re == 0) check_eq("rc3_first_round_en", 32'(cyc - a3), 32'd4);
        else check_eq("rc3_round_period", 32'(cyc - last_re), 32'd3);
        last_re = cyc;
        n_re++;
      end
      ok = out_valid3;
    end
    check_eq("rc3_done", 32'(ok), 32'd1);
    check_eq("rc3_latency", 32'(cyc - a3), 32'(LAT3));
    check_eq("rc3_round_count", 32'(n_re), 32'(ROUNDS));
    tick();
    repeat (2) tick();

    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
